// File: rtl/video_mode_sequencer.sv
// Raster timing generator for the HDMI transmit path. Mode changes are taken over
// a valid/ready handshake, applied at the last pixel of a frame, then followed by one muted frame.
module video_mode_sequencer (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic [3:0]  mode_req,
    input  logic        mode_valid,
    output logic        mode_ready,
    output logic        mode_err,
    output logic [3:0]  active_mode,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        h_sync,
    output logic        v_sync,
    output logic        data_enable,
    output logic        frame_start,
    output logic        locked
);

    typedef enum logic [1:0] {
        ST_MUTE,
        ST_RUN,
        ST_PENDING
    } state_t;

    // Timing table indexed by mode bit 0: entry 0 is 640x480@60, entry 1 is the small simulation raster.
    localparam logic [11:0] H_ACTIVE [2] = '{12'd640, 12'd16};
    localparam logic [11:0] H_FP     [2] = '{12'd16,  12'd2};
    localparam logic [11:0] H_SYNC   [2] = '{12'd96,  12'd4};
    localparam logic [11:0] H_TOTAL  [2] = '{12'd800, 12'd24};
    localparam logic [11:0] V_ACTIVE [2] = '{12'd480, 12'd8};
    localparam logic [11:0] V_FP     [2] = '{12'd10,  12'd1};
    localparam logic [11:0] V_SYNC   [2] = '{12'd2,   12'd2};
    localparam logic [11:0] V_TOTAL  [2] = '{12'd525, 12'd12};

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_h_count;
    logic [11:0] r_v_count;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_data_enable;
    logic        r_frame_start;
    logic        r_mode_err;
    logic [3:0]  r_active_mode;
    logic [3:0]  r_pend_mode;

    logic        w_cur_sel;
    logic        w_next_sel;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_last_pixel;
    logic [11:0] w_h_next;
    logic [11:0] w_v_next;
    logic [11:0] w_hs_lo;
    logic [11:0] w_hs_hi;
    logic [11:0] w_vs_lo;
    logic [11:0] w_vs_hi;
    logic        w_h_sync_next;
    logic        w_v_sync_next;
    logic        w_de_next;
    logic        w_supported;
    logic        w_accept;
    logic        w_load;
    logic        w_latch;
    logic        w_err_next;

    // Only codes 0 and 1 can ever become active, so bit 0 selects the table entry.
    assign w_cur_sel    = r_active_mode[0];
    assign w_h_last     = (r_h_count == H_TOTAL[w_cur_sel] - 12'd1);
    assign w_v_last     = (r_v_count == V_TOTAL[w_cur_sel] - 12'd1);
    assign w_last_pixel = w_h_last && w_v_last;

    assign w_h_next = w_h_last ? 12'd0 : r_h_count + 12'd1;
    assign w_v_next = !w_h_last ? r_v_count :
                      (w_v_last ? 12'd0 : r_v_count + 12'd1);

    assign w_supported = (mode_req <= 4'd1);
    assign w_accept    = (r_state == ST_RUN) && mode_valid;
    assign w_load      = (r_state == ST_PENDING) && w_last_pixel;
    assign w_err_next  = w_accept && !w_supported;

    // Registered outputs describe the next count, so they must use the mode that count belongs to.
    assign w_next_sel = w_load ? r_pend_mode[0] : r_active_mode[0];
    assign w_hs_lo    = H_ACTIVE[w_next_sel] + H_FP[w_next_sel];
    assign w_hs_hi    = w_hs_lo + H_SYNC[w_next_sel];
    assign w_vs_lo    = V_ACTIVE[w_next_sel] + V_FP[w_next_sel];
    assign w_vs_hi    = w_vs_lo + V_SYNC[w_next_sel];

    assign w_h_sync_next = !((w_h_next >= w_hs_lo) && (w_h_next < w_hs_hi));
    assign w_v_sync_next = !((w_v_next >= w_vs_lo) && (w_v_next < w_vs_hi));
    assign w_de_next     = (w_h_next < H_ACTIVE[w_next_sel]) &&
                           (w_v_next < V_ACTIVE[w_next_sel]) &&
                           (w_state_next != ST_MUTE);

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_MUTE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        mode_ready   = 1'b0;
        locked       = 1'b0;
        case (r_state)
            ST_MUTE: begin
                if (w_last_pixel) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                mode_ready = 1'b1;
                locked     = 1'b1;
                if (w_accept && w_supported && (mode_req != r_active_mode)) begin
                    w_state_next = ST_PENDING;
                    w_latch      = 1'b1;
                end
            end
            ST_PENDING: begin
                if (w_last_pixel) begin
                    w_state_next = ST_MUTE;
                end
            end
            default: begin
                w_state_next = ST_MUTE;
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_h_count     <= 12'd0;
            r_v_count     <= 12'd0;
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_data_enable <= 1'b0;
            r_frame_start <= 1'b0;
            r_mode_err    <= 1'b0;
            r_active_mode <= 4'd0;
            r_pend_mode   <= 4'd0;
        end else begin
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_h_sync      <= w_h_sync_next;
            r_v_sync      <= w_v_sync_next;
            r_data_enable <= w_de_next;
            r_frame_start <= w_last_pixel;
            r_mode_err    <= w_err_next;
            if (w_latch) begin
                r_pend_mode <= mode_req;
            end
            if (w_load) begin
                r_active_mode <= r_pend_mode;
            end
        end
    end

    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign data_enable = r_data_enable;
    assign frame_start = r_frame_start;
    assign mode_err    = r_mode_err;
    assign active_mode = r_active_mode;

endmodule

// File: doc/video_mode_sequencer.md
# video_mode_sequencer

Owns the raster timing for the HDMI transmit path and sequences video-mode changes. Holds the per-mode timing table, runs the horizontal and vertical counters, and drives sync and data-enable to the pixel pipeline. Mode changes arrive over a valid/ready handshake and are applied only at a frame boundary, followed by one muted frame so the sink never sees a torn frame.

## Interface
Parameters:
- none. The mode table is fixed in RTL.

Ports:
- clock_25  in  1  pixel clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- mode_req  in  4  requested mode code
- mode_valid  in  1  request strobe
- mode_ready  out  1  sequencer can accept a request this cycle
- mode_err  out  1  one-cycle pulse; the request was an unsupported code
- active_mode  out  4  mode currently driving timing
- h_count  out  12  horizontal position, 0 .. htotal-1
- v_count  out  12  vertical line, 0 .. vtotal-1
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- data_enable  out  1  active-pixel qualifier
- frame_start  out  1  one-cycle pulse when the counters enter (0,0)
- locked  out  1  timing stable, no change pending, not muted

## Operation
- Mode table, as active/front porch/sync/back porch/total:
  - mode 0, horizontal: 640/16/96/48/800.
  - mode 0, vertical: 480/10/2/33/525.
  - mode 1 (simulation mode), horizontal: 16/2/4/2/24.
  - mode 1 (simulation mode), vertical: 8/1/2/1/12.
  - Codes 2–15 are unsupported.
- Line and frame order is active, front porch, sync, back porch.
- Sync is asserted (low) while `active+fp <= count < active+fp+sync`.
- `data_enable = (h_count < h_active) && (v_count < v_active) && !mute`.
- `h_count` increments every cycle and wraps at htotal-1. `v_count` increments when `h_count` wraps, and wraps at vtotal-1.
- All arithmetic is unsigned 12-bit. There is no overflow, because the largest total is 800.
- FSM states are MUTE, RUN and PENDING.
  - MUTE: syncs run and `data_enable` is forced to 0. At the next `frame_start`, go to RUN.
  - RUN: `mode_ready` = 1.
    - `mode_valid` with an unsupported code: pulse `mode_err` for one cycle and stay in RUN.
    - `mode_valid` with the code equal to `active_mode`: no-op, stay in RUN.
    - Otherwise: latch the code and go to PENDING.
  - PENDING: `mode_ready` = 0; requests are ignored and produce no `mode_err`.
    - Timing continues unchanged until the last pixel of the frame (h=htotal-1, v=vtotal-1).
    - On that edge: load the new parameters, set `active_mode` to the latched code, wrap the counters to (0,0), and go to MUTE.
- `locked` = 1 only in RUN.
- A request is accepted only on a cycle where `mode_valid && mode_ready`.

## Timing
- Reset values:
  - `h_count`/`v_count` = 0.
  - `h_sync`/`v_sync` = 1.
  - `data_enable` = 0, `frame_start` = 0, `mode_err` = 0.
  - `mode_ready` = 0, `locked` = 0.
  - `active_mode` = 0. The FSM enters MUTE.
- `h_sync`, `v_sync`, `data_enable` and `frame_start` are registered and cycle-aligned with the `h_count`/`v_count` values they describe. They are computed from the next-count values, so there is zero skew to the counters.
- `frame_start` is asserted when the counters wrap into (0,0). It is not asserted for the initial (0,0) after reset release.
- After reset release, the first `frame_start` ends MUTE. `locked` and `mode_ready` rise in the same cycle as that `frame_start`.
- Request latency: from acceptance to the new timing is at most one frame. Data resumes after one further muted frame, i.e. `locked` returns on the second `frame_start` after acceptance.
- `mode_err` asserts the cycle after the offending valid.
- If acceptance falls on the frame's last pixel, the switch still waits for the next frame's last pixel. Loading always occurs from PENDING, never in the same cycle as acceptance.
- Asserting reset mid-frame or mid-PENDING discards the pending request and reverts to mode 0 immediately (asynchronous).

## Test plan
- Reset, mode 0: run 800×525 cycles. Check that `h_sync` is low for h=656..751, `v_sync` is low for v=490..491, and `data_enable` counts 0 during the mute frame. Check that `locked` rises at cycle 420000 after release.
- Mode 0 to mode 1: request mode 1 mid-frame. Check `mode_ready` falls and `h_count` reaches 799/524 before wrapping. Then check the 24-cycle line, `h_sync` low for h=18..21, `v_sync` low for v=9..10, `data_enable` = 0 for 288 cycles, and `locked` = 1 afterward.
- Locked in mode 1: check exactly 128 `data_enable` cycles per 288-cycle frame and one `frame_start` per frame.
- Unsupported code: request code 7 in RUN. Check a single `mode_err` pulse, `active_mode` unchanged, and `locked` held at 1. Request code 7 in PENDING: check no `mode_err`.
- Same-mode request: request mode 1 while in mode 1. Check no mute, no counter disturbance, and `locked` stays 1.
- Reset in PENDING: assert `reset_n` low while the switch to mode 1 is pending. Check all outputs take their reset values immediately and `active_mode` = 0 after release.
